// File: rtl/cdc_handshake_rx.sv
// Destination end of a toggle req/ack clock-domain-crossing handshake, clkB domain only.
// Optional parity check is compiled in when CDC_RX_PARITY_EN is defined.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no word held; waiting for a new request toggle
// ST_WAIT | word held on data_out with valid_out=1; waiting for ready_in
module cdc_handshake_rx #(
    parameter int DATA_W      = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clkB,
    input  logic              rstB,
    input  logic              req_tgl_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              ready_in,
`ifdef CDC_RX_PARITY_EN
    input  logic              parity_in,
    output logic              par_err_out,
`endif
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              ack_tgl_out,
    output logic              overrun_out
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_sync;
    logic                   req_seen;
    logic                   new_req;
    logic [0:0]             state;

    assign req_sync = sync_q[SYNC_STAGES-1];
    assign new_req  = (req_sync != req_seen);

    always_ff @(posedge clkB or negedge rstB) begin
        if (!rstB) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req_tgl_in};
        end
    end

    // req_seen only advances on capture, so a request arriving during WAIT stays pending
    always_ff @(posedge clkB or negedge rstB) begin
        if (!rstB) begin
            state       <= ST_IDLE;
            req_seen    <= 1'b0;
            data_out    <= '0;
            valid_out   <= 1'b0;
            ack_tgl_out <= 1'b0;
            overrun_out <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (new_req) begin
                        data_out  <= data_in;
                        valid_out <= 1'b1;
                        req_seen  <= req_sync;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (new_req) begin
                        overrun_out <= 1'b1;
                    end
                    if (ready_in) begin
                        valid_out   <= 1'b0;
                        ack_tgl_out <= ~ack_tgl_out;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef CDC_RX_PARITY_EN
    // even parity: data_in plus parity_in must hold an even number of ones
    always_ff @(posedge clkB or negedge rstB) begin
        if (!rstB) begin
            par_err_out <= 1'b0;
        end else if (state == ST_IDLE && new_req) begin
            par_err_out <= (^data_in) ^ parity_in;
        end else if (state == ST_WAIT && ready_in) begin
            par_err_out <= 1'b0;
        end
    end
`endif

endmodule
